// File: rtl/pong_pkg.sv
// Shared constants and types for the pong display: raster timing defaults,
// colour constants and the coordinate type used by the ball and paddle blocks.
package pong_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_MOVE_DIV = 2;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic [15:0] COL_BALL   = 16'hFFFF;
  localparam logic [15:0] COL_PADDLE = 16'h07E0;
  localparam logic [15:0] COL_BG     = 16'h0000;

  typedef logic [11:0] coord_t;

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical raster counters with the stage-0 decode of the
// active region and the raw (unaligned) sync pulses.
module vga_sync_counter
  import pong_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic   vga_clk,
  input  logic   sys_rst_n,
  output coord_t h_cnt,
  output coord_t v_cnt,
  output logic   act0,
  output logic   hs0,
  output logic   vs0
);

  localparam coord_t H_LAST     = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST     = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS      = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS      = coord_t'(V_ACTIVE);
  localparam coord_t HS_START   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END     = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END     = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  // The line counter only moves when the pixel counter wraps.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  always_comb begin
    act0 = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs0  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs0  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  end

endmodule

// File: rtl/pong_vga_scan.sv
// Pong raster scan: pixel coordinates out, hit flags back in, and a 2-clock
// aligned colour/sync stream for the DAC plus a frame-locked move strobe.
module pong_vga_scan
  import pong_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int MOVE_DIV = DEF_MOVE_DIV
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        ball_hit,
  input  logic        paddle_hit,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [15:0] rgb,
  output logic        move_tick
);

  coord_t      h_cnt;
  coord_t      v_cnt;
  logic        act0, hs0, vs0;
  logic        act1, hs1, vs1;
  logic [15:0] rgb_next;
  logic [3:0]  frame_cnt;
  logic        frame_evt;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_counter (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .act0      (act0),
    .hs0       (hs0),
    .vs0       (vs0)
  );

  assign pixel_x   = act0 ? h_cnt : '0;
  assign pixel_y   = act0 ? v_cnt : '0;
  assign frame_evt = (h_cnt == '0) && (v_cnt == coord_t'(V_ACTIVE));

  // Blanking forces black regardless of what the object blocks report.
  always_comb begin
    rgb_next = COL_BG;
    if (act1) begin
      if (ball_hit)        rgb_next = COL_BALL;
      else if (paddle_hit) rgb_next = COL_PADDLE;
    end
  end

  // Stage 1 waits for the hit flags, stage 2 registers the aligned outputs.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      act1     <= 1'b0;
      hs1      <= 1'b1;
      vs1      <= 1'b1;
      video_on <= 1'b0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      rgb      <= '0;
    end else begin
      act1     <= act0;
      hs1      <= hs0;
      vs1      <= vs0;
      video_on <= act1;
      hsync    <= hs1;
      vsync    <= vs1;
      rgb      <= rgb_next;
    end
  end

  // Frames are counted only while the game runs, so a fresh start always
  // waits MOVE_DIV first-blank-line events before the first strobe.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt <= '0;
      move_tick <= 1'b0;
    end else if (!start) begin
      frame_cnt <= '0;
      move_tick <= 1'b0;
    end else begin
      move_tick <= 1'b0;
      if (frame_evt) begin
        if (frame_cnt == 4'(MOVE_DIV - 1)) begin
          move_tick <= 1'b1;
          frame_cnt <= '0;
        end else begin
          frame_cnt <= frame_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pong_vga_scan.sv
// Bench for pong_vga_scan: a reduced-timing instance for whole-frame behaviour
// and a default-timing instance for the first lines, both against a raster model.
module tb_pong_vga_scan;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ball_hit = 1'b0;
  logic        paddle_hit = 1'b0;

  logic [11:0] s_pixel_x, s_pixel_y, b_pixel_x, b_pixel_y;
  logic        s_hsync, s_vsync, s_video_on, s_move_tick;
  logic        b_hsync, b_vsync, b_video_on, b_move_tick;
  logic [15:0] s_rgb, b_rgb;

  // Timing table: index 0 = reduced instance, index 1 = full 640x480 instance.
  int prm_ha[2] = '{40, 640};
  int prm_hf[2] = '{4, 16};
  int prm_hs[2] = '{8, 96};
  int prm_hb[2] = '{6, 48};
  int prm_va[2] = '{30, 480};
  int prm_vf[2] = '{3, 10};
  int prm_vs[2] = '{2, 2};
  int prm_vb[2] = '{5, 33};
  localparam int MOVE_DIV = 2;

  int t;
  int evt[2];
  int passed;
  int total;
  bit force_hits;
  bit after_mid;
  logic [11:0] last_px, last_py;

  always #5 vga_clk = ~vga_clk;

  pong_vga_scan #(
    .H_ACTIVE (40), .H_FP (4), .H_SYNC (8), .H_BP (6),
    .V_ACTIVE (30), .V_FP (3), .V_SYNC (2), .V_BP (5),
    .MOVE_DIV (MOVE_DIV)
  ) u_small (
    .vga_clk (vga_clk), .sys_rst_n (sys_rst_n), .start (start),
    .ball_hit (ball_hit), .paddle_hit (paddle_hit),
    .pixel_x (s_pixel_x), .pixel_y (s_pixel_y),
    .hsync (s_hsync), .vsync (s_vsync), .video_on (s_video_on),
    .rgb (s_rgb), .move_tick (s_move_tick)
  );

  pong_vga_scan u_big (
    .vga_clk (vga_clk), .sys_rst_n (sys_rst_n), .start (start),
    .ball_hit (ball_hit), .paddle_hit (paddle_hit),
    .pixel_x (b_pixel_x), .pixel_y (b_pixel_y),
    .hsync (b_hsync), .vsync (b_vsync), .video_on (b_video_on),
    .rgb (b_rgb), .move_tick (b_move_tick)
  );

  // Raster position and decode for the clock tt cycles after reset release;
  // negative tt means the pipeline still holds reset values.
  function automatic void decode(input int tt, input int inst, output int h, output int v,
                                 output bit act, output bit hs, output bit vs);
    int ht, vt, p;
    ht = prm_ha[inst] + prm_hf[inst] + prm_hs[inst] + prm_hb[inst];
    vt = prm_va[inst] + prm_vf[inst] + prm_vs[inst] + prm_vb[inst];
    if (tt < 0) begin
      h = 0; v = 0; act = 1'b0; hs = 1'b1; vs = 1'b1;
    end else begin
      p   = tt % (ht * vt);
      h   = p % ht;
      v   = p / ht;
      act = (h < prm_ha[inst]) && (v < prm_va[inst]);
      hs  = !((h >= prm_ha[inst] + prm_hf[inst]) && (h < prm_ha[inst] + prm_hf[inst] + prm_hs[inst]));
      vs  = !((v >= prm_va[inst] + prm_vf[inst]) && (v < prm_va[inst] + prm_vf[inst] + prm_vs[inst]));
    end
  endfunction

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("[TB] FAIL %s t=%0d got=%0h expected=%0h", name, t, got, exp);
  endtask

  task automatic checkOutput(input int inst, input logic [11:0] px, input logic [11:0] py,
                             input logic hs_o, input logic vs_o, input logic von,
                             input logic [15:0] rgb_o, input logic mt);
    int h, v, h2, v2, hp, vp;
    bit a, hsx, vsx, a2, hs2, vs2, ap, hsp, vsp;
    int exp_rgb;
    int exp_mt;
    string tag;
    tag = (inst == 0) ? "small" : "big";
    decode(t, inst, h, v, a, hsx, vsx);
    decode(t - 2, inst, h2, v2, a2, hs2, vs2);
    exp_rgb = !a2 ? 0 : ball_hit ? 32'hFFFF : paddle_hit ? 32'h07E0 : 0;
    exp_mt = 0;
    if (t > 0) begin
      decode(t - 1, inst, hp, vp, ap, hsp, vsp);
      if (!start) evt[inst] = 0;
      else if (hp == 0 && vp == prm_va[inst]) begin
        evt[inst]++;
        exp_mt = (evt[inst] % MOVE_DIV == 0) ? 1 : 0;
      end
    end
    check({tag, ".pixel_x"}, int'(px), a ? h : 0);
    check({tag, ".pixel_y"}, int'(py), a ? v : 0);
    check({tag, ".hsync"}, int'(hs_o), int'(hs2));
    check({tag, ".vsync"}, int'(vs_o), int'(vs2));
    check({tag, ".video_on"}, int'(von), int'(a2));
    check({tag, ".rgb"}, int'(rgb_o), exp_rgb);
    check({tag, ".move_tick"}, int'(mt), exp_mt);
  endtask

  // Hand-computed anchor points for the reduced (58x40) and full (800x525) rasters.
  task automatic literalChecks();
    if (!after_mid) begin
      case (t)
        45:    check("lit.s_hsync_45", s_hsync, 1);
        46:    check("lit.s_hsync_46", s_hsync, 0);
        53:    check("lit.s_hsync_53", s_hsync, 0);
        54:    check("lit.s_hsync_54", s_hsync, 1);
        104:   check("lit.s_hsync_line1", s_hsync, 0);
        639:   check("lit.b_px_639", b_pixel_x, 639);
        640:   check("lit.b_px_640", b_pixel_x, 0);
        641:   check("lit.b_von_641", b_video_on, 1);
        642:   check("lit.b_von_642", b_video_on, 0);
        657:   check("lit.b_hsync_657", b_hsync, 1);
        658:   check("lit.b_hsync_658", b_hsync, 0);
        718:   check("lit.s_rgb_x20", s_rgb, 16'h0000);
        719:   check("lit.s_rgb_x21", s_rgb, 16'hFFFF);
        727:   check("lit.s_rgb_x29", s_rgb, 16'hFFFF);
        728:   check("lit.s_rgb_x30", s_rgb, 16'h07E0);
        733:   check("lit.s_rgb_x35", s_rgb, 16'h07E0);
        734:   check("lit.s_rgb_x36", s_rgb, 16'h0000);
        753:   check("lit.b_hsync_753", b_hsync, 0);
        754:   check("lit.b_hsync_754", b_hsync, 1);
        799:   check("lit.b_px_799", b_pixel_x, 0);
        1458:  check("lit.b_hsync_line1", b_hsync, 0);
        1687:  check("lit.s_py_29", s_pixel_y, 29);
        1741:  check("lit.s_tick_stopped", s_move_tick, 0);
        1745:  check("lit.s_py_line30", s_pixel_y, 0);
        1747:  check("lit.s_von_line30", s_video_on, 0);
        1915:  check("lit.s_vsync_1915", s_vsync, 1);
        1916:  check("lit.s_vsync_1916", s_vsync, 0);
        2031:  check("lit.s_vsync_2031", s_vsync, 0);
        2032:  check("lit.s_vsync_2032", s_vsync, 1);
        4061:  check("lit.s_tick_stopped2", s_move_tick, 0);
        4236:  check("lit.s_vsync_frame2", s_vsync, 0);
        11020: check("lit.s_tick_11020", s_move_tick, 0);
        11021: check("lit.s_tick_11021", s_move_tick, 1);
        11022: check("lit.s_tick_11022", s_move_tick, 0);
        13341: check("lit.s_tick_odd_evt", s_move_tick, 0);
        15661: check("lit.s_tick_15661", s_move_tick, 1);
        default: ;
      endcase
    end else begin
      case (t)
        0: begin
          check("lit.s_px_restart", s_pixel_x, 0);
          check("lit.s_py_restart", s_pixel_y, 0);
        end
        5: begin
          check("lit.s_px_5", s_pixel_x, 5);
          check("lit.b_px_5", b_pixel_x, 5);
        end
        4061: check("lit.s_tick_after_reset", s_move_tick, 1);
        default: ;
      endcase
    end
  endtask

  // Registered consumer: flags seen on the next edge describe the pixel of
  // the previous cycle, as the ball/paddle blocks would present them.
  task automatic applyStimulus();
    if (force_hits) begin
      ball_hit   = 1'b1;
      paddle_hit = 1'b1;
    end else begin
      ball_hit   = (last_py == 12'd12) && (last_px >= 12'd21) && (last_px <= 12'd29);
      paddle_hit = (last_py == 12'd12) && (last_px >= 12'd25) && (last_px <= 12'd35);
    end
    last_px = s_pixel_x;
    last_py = s_pixel_y;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput(0, s_pixel_x, s_pixel_y, s_hsync, s_vsync, s_video_on, s_rgb, s_move_tick);
      checkOutput(1, b_pixel_x, b_pixel_y, b_hsync, b_vsync, b_video_on, b_rgb, b_move_tick);
      literalChecks();
      applyStimulus();
      @(negedge vga_clk);
      t++;
    end
  endtask

  initial begin
    passed = 0; total = 0; t = 0;
    evt[0] = 0; evt[1] = 0;
    force_hits = 1'b0; after_mid = 1'b0;
    last_px = '0; last_py = '0;
    repeat (3) @(negedge vga_clk);
    sys_rst_n = 1'b1;

    // Three frames of free run with start low and the object rectangle on row 12.
    run(7000);

    // Start rises mid-frame; both hit flags held high from here on.
    start = 1'b1;
    force_hits = 1'b1;
    run(9840);

    // Asynchronous reset at small (20,10) / big (40,21), between clock edges.
    checkOutput(0, s_pixel_x, s_pixel_y, s_hsync, s_vsync, s_video_on, s_rgb, s_move_tick);
    checkOutput(1, b_pixel_x, b_pixel_y, b_hsync, b_vsync, b_video_on, b_rgb, b_move_tick);
    check("mid.s_px_before", s_pixel_x, 20);
    check("mid.s_py_before", s_pixel_y, 10);
    check("mid.s_rgb_before", s_rgb, 16'hFFFF);
    check("mid.b_px_before", b_pixel_x, 40);
    sys_rst_n = 1'b0;
    #1;
    check("mid.s_px_reset", s_pixel_x, 0);
    check("mid.s_py_reset", s_pixel_y, 0);
    check("mid.s_rgb_reset", s_rgb, 0);
    check("mid.s_von_reset", s_video_on, 0);
    check("mid.s_hsync_reset", s_hsync, 1);
    check("mid.s_vsync_reset", s_vsync, 1);
    check("mid.s_tick_reset", s_move_tick, 0);
    check("mid.b_px_reset", b_pixel_x, 0);
    check("mid.b_von_reset", b_video_on, 0);
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    t = 0;
    evt[0] = 0; evt[1] = 0;
    after_mid = 1'b1;
    run(4500);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pong_vga_scan.md
# pong_vga_scan

Raster timing generator for the pong display at 640x480@60 Hz with a 25.175 MHz `vga_clk`. It drives the pixel coordinates that the ball and paddle blocks sample, and receives their per-pixel hit flags back. From those flags it produces the colour stream and the aligned sync outputs for the DAC. It also generates the frame-locked `move_tick` pulse that advances game objects once per N frames.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch, in clocks
- `H_SYNC`, 96, hsync width, in clocks
- `H_BP`, 48, horizontal back porch, in clocks
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch, in lines
- `V_SYNC`, 2, vsync width, in lines
- `V_BP`, 33, vertical back porch, in lines
- `MOVE_DIV`, 2, frames per `move_tick` pulse (legal range 1..15)

Ports:
- `vga_clk`  in  1  pixel clock
- `sys_rst_n`  in  1  reset; **one clock; reset is asynchronous and active-low**
- `start`  in  1  game running; gates `move_tick`
- `ball_hit`  in  1  ball covers the pixel, registered by the consumer one clock after `pixel_x`/`pixel_y`
- `paddle_hit`  in  1  paddle covers the pixel, same one-clock latency as `ball_hit`
- `pixel_x`  out  12  current column, 0..H_ACTIVE-1; 0 while blanking
- `pixel_y`  out  12  current row, 0..V_ACTIVE-1; 0 while blanking
- `hsync`  out  1  active-low horizontal sync, aligned with `rgb`
- `vsync`  out  1  active-low vertical sync, aligned with `rgb`
- `video_on`  out  1  `rgb` is in the visible area, aligned with `rgb`
- `rgb`  out  16  RGB565 pixel colour
- `move_tick`  out  1  single-cycle object-advance strobe

## Operation
- **Counters**
  - `h_cnt` counts 0..H_TOTAL-1, where H_TOTAL = 800; it wraps to 0.
  - `v_cnt` increments only when `h_cnt` wraps. It counts 0..V_TOTAL-1, where V_TOTAL = 525; it wraps to 0.
- **Stage 0 (counters)**
  - Active region: `act0` = (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE).
  - `pixel_x` = `act0` ? `h_cnt` : 0.
  - `pixel_y` = `act0` ? `v_cnt` : 0.
  - `hs0` is low for H_ACTIVE+H_FP <= `h_cnt` < H_ACTIVE+H_FP+H_SYNC.
  - `vs0` is low for V_ACTIVE+V_FP <= `v_cnt` < V_ACTIVE+V_FP+V_SYNC.
- **Stage 1**: `act0`, `hs0` and `vs0` are registered once, to meet the hit flags.
- **Stage 2 (output registers)**
  - `rgb` = 0 when stage-1 active is 0.
  - Otherwise `ball_hit` gives 16'hFFFF; ball has priority over paddle.
  - Otherwise `paddle_hit` gives 16'h07E0.
  - Otherwise 16'h0000.
  - `hsync`, `vsync` and `video_on` are the stage-1 values, registered.
- **Move tick**
  - A 4-bit `frame_cnt` advances at the frame event: `h_cnt` == 0 && `v_cnt` == V_ACTIVE, which is the first blank line.
  - When `start` = 1 and `frame_cnt` == MOVE_DIV-1: `move_tick` = 1 for exactly one clock, and `frame_cnt` is set to 0.
  - When `start` = 0: `frame_cnt` is held at 0 and `move_tick` stays 0.
  - When `start` rises mid-frame, the first tick comes MOVE_DIV frame events later.
- **Reset values**
  - `h_cnt`, `v_cnt` and `frame_cnt` = 0.
  - `hsync`, `vsync` and the pipeline sync bits = 1.
  - `video_on` and the pipeline active bits = 0.
  - `rgb` = 0, `move_tick` = 0.
  - Reset mid-frame restarts at (0,0) on the first clock after release.
- **Widths**: counters are 12-bit; all compares are unsigned; no parameter sum exceeds 4095.

## Timing
- `pixel_x`/`pixel_y` have zero latency from the counters.
- `rgb`, `hsync`, `vsync` and `video_on` have 2-clock latency from the matching counter value, and are mutually aligned.
- The first `hsync` low after reset is at clock 656+2 = 658; it lasts 96 clocks.
- `vsync` is low for 2 lines (1600 clocks), starting on line 490.
- `move_tick` asserts on the clock after the counters read (0, 480). That is the start of vertical blank, so objects update outside the visible area.

## Structure
- Shared package `pong_pkg` holds:
  - The timing defaults and H_TOTAL/V_TOTAL.
  - Colour constants `COL_BALL`, `COL_PADDLE`, `COL_BG`.
  - The 12-bit coordinate type shared with the ball and paddle blocks.
- One sub-module, `vga_sync_counter`: the h/v counters plus the stage-0 `act0`/`hs0`/`vs0` decode.
- The top level adds the alignment pipeline, the colour mux and the move-tick logic.

## Test plan
- **Reset and free run**
  - Stimulus: reset, then run 2 frames.
  - Required: H period 800 clocks, V period 420000 clocks.
  - Required: `hsync` low at clocks 658..753 of line 0; `vsync` low on lines 490..491.
- **Coordinates**
  - Required at clock 639: `pixel_x` = 639.
  - Required at clocks 640..799: `pixel_x` = 0.
  - Required throughout line 480: `pixel_y` = 0, `video_on` = 0 two clocks later.
- **Colour priority**
  - Model a 1-clock registered consumer that asserts `ball_hit` for `pixel_x` in 321..329 and `paddle_hit` for 325..335 on row 245.
  - Required `rgb` on that row: 16'hFFFF for x = 321..329, 16'h07E0 for x = 330..335, 0 elsewhere.
- **Blanking override**
  - Stimulus: force both hit flags to 1 continuously.
  - Required: `rgb` = 0 whenever `video_on` = 0.
- **Move tick**
  - With `start` = 1 and MOVE_DIV = 2: exactly one 1-clock pulse every 840000 clocks, at line 480.
  - With `start` = 0 for 3 frames: no pulse.
  - Raising `start` gives the first pulse at the 2nd subsequent frame event.
- **Async reset mid-line**
  - Stimulus: assert `sys_rst_n` = 0 at h = 300, v = 100, without a clock edge.
  - Required: outputs take their reset values immediately.
  - Required: after release, counting restarts from (0,0).
